// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer
// Command-driven actuation sequencer for the kinase_activity array ctrl pads.
// A LOAD/MIX/FLUSH command applies a valve pattern, lets it settle, runs the
// selected peristaltic pump for count full cycles, releases the pump and
// returns to IDLE with a one-cycle done pulse. Valve bit 1 = pressurized/closed.
// All pattern outputs are registered: the next-state logic resolves the
// state for the coming cycle and the pattern decode is taken from that.

module kinase_valve_sequencer #(
    parameter int STEP_DIV = 1000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_sel,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [12:0]      ctrl_a,
    output logic [3:0]       ctrl_s,
    output logic [2:0]       pump_a,
    output logic [1:0]       pump_b
);

    localparam int CYC_W = $clog2(STEP_DIV + 1);
    // Holds count * 6 without overflow.
    localparam int PH_W  = CNT_W + 3;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(STEP_DIV - 1);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_MIX   = 2'd2;

    localparam logic [12:0] CA_IDLE  = 13'h1FFF;
    localparam logic [12:0] CA_LOAD  = 13'h1FF8;
    localparam logic [12:0] CA_MIX   = 13'h1FC7;
    localparam logic [12:0] CA_FLUSH = 13'h003F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_PUMP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [3:0]        sel_q, sel_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [PH_W-1:0]   phase_left_q, phase_left_d;
    logic [2:0]        phase_idx_q, phase_idx_d;
    logic [12:0]       ctrl_a_q, ctrl_a_d;
    logic [3:0]        ctrl_s_q, ctrl_s_d;
    logic [2:0]        pump_a_q, pump_a_d;
    logic [1:0]        pump_b_q, pump_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              step_end;
    logic              sel_onehot;
    logic              cmd_reject;
    logic [2:0]        phase_last;

    assign step_end   = (cyc_q == CYC_LAST);
    assign sel_onehot = (cmd_sel != 4'd0) && ((cmd_sel & (cmd_sel - 4'd1)) == 4'd0);
    assign cmd_reject = (cmd_op == OP_NOP) || ((cmd_op == OP_LOAD) && !sel_onehot);
    // MIX drives the 4-phase pump, LOAD/FLUSH the 6-phase pump.
    assign phase_last = (op_q == OP_MIX) ? 3'd3 : 3'd5;

    // Next-state logic: command accept, interval timing, pump stepping, abort.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sel_d        = sel_q;
        cyc_d        = cyc_q;
        phase_left_d = phase_left_q;
        phase_idx_d  = phase_idx_q;
        done_d       = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    sel_d       = cmd_sel;
                    phase_idx_d = 3'd0;
                    if (cmd_op == OP_MIX) begin
                        phase_left_d = {1'b0, cmd_count, 2'b00};
                    end else begin
                        phase_left_d = {1'b0, cmd_count, 2'b00} + {2'b00, cmd_count, 1'b0};
                    end
                    if (cmd_reject) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d      = S_RELEASE;
                    cyc_d        = '0;
                    phase_left_d = '0;
                end else if (step_end) begin
                    cyc_d   = '0;
                    // A zero count skips pumping entirely.
                    state_d = (phase_left_q == '0) ? S_RELEASE : S_PUMP;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_PUMP: begin
                if (abort) begin
                    state_d      = S_RELEASE;
                    cyc_d        = '0;
                    phase_left_d = '0;
                    phase_idx_d  = 3'd0;
                end else if (step_end) begin
                    cyc_d = '0;
                    if (phase_left_q == PH_W'(1)) begin
                        state_d      = S_RELEASE;
                        phase_left_d = '0;
                        phase_idx_d  = 3'd0;
                    end else begin
                        phase_left_d = phase_left_q - PH_W'(1);
                        phase_idx_d  = (phase_idx_q == phase_last) ? 3'd0 : phase_idx_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_RELEASE: begin
                if (step_end) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs line up with it.
    always_comb begin
        ctrl_a_d = CA_IDLE;
        ctrl_s_d = 4'hF;
        pump_a_d = 3'b111;
        pump_b_d = 2'b11;
        busy_d   = (state_d != S_IDLE);

        if (state_d != S_IDLE) begin
            case (op_d)
                OP_LOAD: begin
                    ctrl_a_d = CA_LOAD;
                    ctrl_s_d = ~sel_d;
                end
                OP_MIX: begin
                    ctrl_a_d = CA_MIX;
                    ctrl_s_d = 4'hF;
                end
                default: begin
                    ctrl_a_d = CA_FLUSH;
                    ctrl_s_d = 4'h0;
                end
            endcase
        end

        if (state_d == S_PUMP) begin
            if (op_d == OP_MIX) begin
                case (phase_idx_d)
                    3'd0:    pump_b_d = 2'b10;
                    3'd1:    pump_b_d = 2'b00;
                    3'd2:    pump_b_d = 2'b01;
                    default: pump_b_d = 2'b11;
                endcase
            end else begin
                case (phase_idx_d)
                    3'd0:    pump_a_d = 3'b011;
                    3'd1:    pump_a_d = 3'b001;
                    3'd2:    pump_a_d = 3'b101;
                    3'd3:    pump_a_d = 3'b100;
                    3'd4:    pump_a_d = 3'b110;
                    default: pump_a_d = 3'b010;
                endcase
            end
        end
    end

    // State and output registers; reset returns everything to IDLE silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            sel_q        <= 4'd0;
            cyc_q        <= '0;
            phase_left_q <= '0;
            phase_idx_q  <= 3'd0;
            ctrl_a_q     <= CA_IDLE;
            ctrl_s_q     <= 4'hF;
            pump_a_q     <= 3'b111;
            pump_b_q     <= 2'b11;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sel_q        <= sel_d;
            cyc_q        <= cyc_d;
            phase_left_q <= phase_left_d;
            phase_idx_q  <= phase_idx_d;
            ctrl_a_q     <= ctrl_a_d;
            ctrl_s_q     <= ctrl_s_d;
            pump_a_q     <= pump_a_d;
            pump_b_q     <= pump_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign ctrl_a    = ctrl_a_q;
    assign ctrl_s    = ctrl_s_q;
    assign pump_a    = pump_a_q;
    assign pump_b    = pump_b_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Bench for kinase_valve_sequencer with STEP_DIV = 4.
// Each command's per-cycle expected outputs are derived from the timeline
// (settle / pump phases / release / done) and queued when the command is
// driven, then popped and compared on every falling edge.

module tb_kinase_valve_sequencer;

    localparam int STEP = 4;
    localparam int CW   = 16;

    typedef struct packed {
        logic [12:0] ca;
        logic [3:0]  cs;
        logic [2:0]  pa;
        logic [1:0]  pb;
        logic        busy;
        logic        done;
        logic        err;
        logic        rdy;
    } obs_t;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [3:0] sel;
        int         cnt;
        int         abort_at;   // cycle offset after accept, 0 = none
        bit         chained;    // issue in the done cycle of the previous command
        int         exp_done;   // expected done cycle offset, 0 = never
        int         exp_err;    // expected error cycle offset, 0 = never
    } vec_t;

    localparam obs_t IDLE_OBS = '{ca: 13'h1FFF, cs: 4'hF, pa: 3'b111, pb: 2'b11,
                                  busy: 1'b0, done: 1'b0, err: 1'b0, rdy: 1'b1};

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [3:0]      cmd_sel;
    logic [CW-1:0]   cmd_count;
    logic            abort;
    logic            busy;
    logic            done;
    logic            error;
    logic [12:0]     ctrl_a;
    logic [3:0]      ctrl_s;
    logic [2:0]      pump_a;
    logic [1:0]      pump_b;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    kinase_valve_sequencer #(.STEP_DIV(STEP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_count(cmd_count), .abort(abort),
        .busy(busy), .done(done), .error(error), .ctrl_a(ctrl_a), .ctrl_s(ctrl_s),
        .pump_a(pump_a), .pump_b(pump_b)
    );

    function automatic logic [2:0] pa_phase(input int ph);
        case (ph)
            0: return 3'b011;
            1: return 3'b001;
            2: return 3'b101;
            3: return 3'b100;
            4: return 3'b110;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [1:0] pb_phase(input int ph);
        case (ph)
            0: return 2'b10;
            1: return 2'b00;
            2: return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    function automatic int release_start(input logic [1:0] op, input int cnt, input int a);
        int p;
        int plen;
        p    = (op == 2'd2) ? 4 : 6;
        plen = STEP * p * cnt;
        if (a >= 1 && a <= STEP + plen) return a + 1;
        return STEP + plen + 1;
    endfunction

    // Expected outputs k cycles after an accepted (non-rejected) command.
    function automatic obs_t exp_at(input logic [1:0] op, input logic [3:0] sel,
                                    input int cnt, input int a, input int k);
        obs_t e;
        int   p;
        int   rel;
        int   dn;
        int   ph;
        e   = IDLE_OBS;
        p   = (op == 2'd2) ? 4 : 6;
        rel = release_start(op, cnt, a);
        dn  = rel + STEP;
        if (k == dn) begin
            e.done = 1'b1;
            return e;
        end
        if (k > dn || k < 1) return e;
        e.busy = 1'b1;
        e.rdy  = 1'b0;
        case (op)
            2'd1: begin e.ca = 13'h1FF8; e.cs = ~sel; end
            2'd2: begin e.ca = 13'h1FC7; e.cs = 4'hF; end
            default: begin e.ca = 13'h003F; e.cs = 4'h0; end
        endcase
        if (k > STEP && k < rel) begin
            ph = ((k - STEP - 1) / STEP) % p;
            if (op == 2'd2) e.pb = pb_phase(ph);
            else            e.pa = pa_phase(ph);
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{ca: ctrl_a, cs: ctrl_s, pa: pump_a, pb: pump_b,
              busy: busy, done: done, err: error, rdy: cmd_ready};
        return o;
    endfunction

    task automatic check_obs(input string name, input int k);
        obs_t e;
        obs_t o;
        o = sample();
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s cyc %0d: scoreboard empty, got ca=%h", name, k, o.ca);
            return;
        end
        e = exp_q.pop_front();
        if (o !== e) begin
            errors++;
            $display("FAIL %s cyc %0d: got ca=%h cs=%b pa=%b pb=%b busy=%b done=%b err=%b rdy=%b, expected ca=%h cs=%b pa=%b pb=%b busy=%b done=%b err=%b rdy=%b",
                     name, k, o.ca, o.cs, o.pa, o.pb, o.busy, o.done, o.err, o.rdy,
                     e.ca, e.cs, e.pa, e.pb, e.busy, e.done, e.err, e.rdy);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit   rej;
        int   n;
        int   done_at;
        int   err_at;
        obs_t e;
        if (!v.chained) @(negedge clk);
        check_int({v.name, " ready_before"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_sel   = v.sel;
        cmd_count = CW'(v.cnt);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(3));
        cmd_sel   = 4'($urandom_range(15));
        cmd_count = CW'($urandom_range(65535));

        rej = (v.op == 2'd0) || (v.op == 2'd1 && !$onehot(v.sel));
        if (rej) begin
            n = 2;
            e = IDLE_OBS;
            e.err = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(IDLE_OBS);
        end else begin
            n = release_start(v.op, v.cnt, v.abort_at) + STEP;
            for (int k = 1; k <= n; k++) exp_q.push_back(exp_at(v.op, v.sel, v.cnt, v.abort_at, k));
        end

        done_at = 0;
        err_at  = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (done === 1'b1 && done_at == 0) done_at = k;
            if (error === 1'b1 && err_at == 0) err_at = k;
            check_obs(v.name, k);
            abort = (k == v.abort_at);
        end
        abort = 1'b0;
        check_int({v.name, " done_at"}, done_at, v.exp_done);
        check_int({v.name, " err_at"}, err_at, v.exp_err);
        $display("txn %-14s op=%0d sel=%b cnt=%0d abort_at=%0d -> done_at=%0d err_at=%0d",
                 v.name, v.op, v.sel, v.cnt, v.abort_at, done_at, err_at);
    endtask

    initial begin
        vecs[0]  = '{"load_c1",      2'd1, 4'b0010, 1, 0,  1'b0, 33, 0};
        vecs[1]  = '{"mix_c2",       2'd2, 4'b0000, 2, 0,  1'b0, 41, 0};
        vecs[2]  = '{"flush_c0",     2'd3, 4'b0000, 0, 0,  1'b0, 9,  0};
        vecs[3]  = '{"load_badsel",  2'd1, 4'b0110, 1, 0,  1'b0, 0,  1};
        vecs[4]  = '{"nop",          2'd0, 4'b0001, 3, 0,  1'b0, 0,  1};
        vecs[5]  = '{"flush_abort",  2'd3, 4'b0000, 5, 10, 1'b0, 15, 0};
        vecs[6]  = '{"load_b2b",     2'd1, 4'b1000, 0, 0,  1'b1, 9,  0};
        vecs[7]  = '{"mix_abort_st", 2'd2, 4'b0000, 1, 2,  1'b1, 7,  0};
        vecs[8]  = '{"load_abt_rel", 2'd1, 4'b0001, 0, 6,  1'b0, 9,  0};
        vecs[9]  = '{"load_sel0",    2'd1, 4'b0000, 2, 0,  1'b0, 0,  1};
        vecs[10] = '{"flush_abt_p1", 2'd3, 4'b0000, 1, 5,  1'b0, 10, 0};
        vecs[11] = '{"mix_c3_b2b",   2'd2, 4'b0100, 3, 0,  1'b1, 57, 0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_sel   = 4'd0;
        cmd_count = '0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(IDLE_OBS);
        check_obs("reset_hold", 0);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(IDLE_OBS);
        check_obs("reset_idle", 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset in the middle of a LOAD pump phase, with abort and a new command also present.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_sel   = 4'b0010;
        cmd_count = CW'(1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back(exp_at(2'd1, 4'b0010, 1, 0, k));
            @(negedge clk);
            check_obs("rst_load", k);
        end
        rst       = 1'b1;
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        for (int k = 11; k <= 14; k++) begin
            exp_q.push_back(IDLE_OBS);
            @(negedge clk);
            check_obs("rst_idle", k);
            rst       = 1'b0;
            abort     = 1'b0;
            cmd_valid = 1'b0;
        end
        $display("txn %-14s LOAD reset in pump -> idle, no done", "rst_in_pump");
        run_vec('{"mix_after_rst", 2'd2, 4'b0000, 2, 0, 1'b0, 41, 0});

        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
